// File: rtl/sobol_seq_gen.sv
// Sobol sequence generator: counter, direction table, LSZ scan.
// Optional random digital shift enabled by SOBOL_SCRAMBLE_EN.
module sobol_seq_gen #(
    parameter int INWD    = 8,
    parameter int LOGINWD = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               restart,
    input  logic               dir_we,
    input  logic [LOGINWD-1:0] dir_addr,
    input  logic [INWD-1:0]    dir_data,
`ifdef SOBOL_SCRAMBLE_EN
    input  logic               scr_we,
    input  logic [INWD-1:0]    scr_mask,
`endif
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INWD-1:0]    out_data,
    output logic               wrap,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [LOGINWD:0] DEPTH = (LOGINWD + 1)'(INWD);

    state_t             state_q;
    state_t             state_d;
    logic [INWD-1:0]    cnt_q;
    logic [INWD-1:0]    x_q;
    logic               wrap_q;
    logic [INWD-1:0]    vtab [INWD];
    logic [LOGINWD-1:0] z;
    logic               all_ones;
    logic               step;
    logic               idle;
    logic               addr_ok;

    assign idle      = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign step      = out_valid & out_ready;
    assign all_ones  = &cnt_q;
    assign addr_ok   = ({1'b0, dir_addr} < DEPTH);
    assign wrap      = wrap_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop dominates start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && !stop) state_d = RUN;
            RUN:  if (stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Least-significant-zero scan of the counter.
    always_comb begin
        z = '0;
        for (int i = INWD - 1; i >= 0; i--) begin
            if (!cnt_q[i]) z = LOGINWD'(i);
        end
    end

    // Counter, sample and wrap pulse; restart beats a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            x_q    <= '0;
            wrap_q <= 1'b0;
        end else if (restart) begin
            cnt_q  <= '0;
            x_q    <= '0;
            wrap_q <= 1'b0;
        end else if (step) begin
            if (all_ones) begin
                cnt_q  <= '0;
                x_q    <= '0;
                wrap_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                x_q    <= x_q ^ vtab[z];
                wrap_q <= 1'b0;
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    // Direction table; writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < INWD; k++) begin
                vtab[k] <= INWD'(1) << (INWD - 1 - k);
            end
        end else if (dir_we && idle && addr_ok) begin
            vtab[dir_addr] <= dir_data;
        end
    end

`ifdef SOBOL_SCRAMBLE_EN
    logic [INWD-1:0] mask_q;

    // Digital-shift mask, loaded while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (scr_we && idle) begin
            mask_q <= scr_mask;
        end
    end

    assign out_data = x_q ^ mask_q;
`else
    assign out_data = x_q;
`endif

endmodule

// File: tb/tb_sobol_seq_gen.sv
// Directed bench for sobol_seq_gen (INWD=8).
// Expected samples come from bit-reversed Gray codes.
module tb_sobol_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, restart;
    logic       dir_we;
    logic [2:0] dir_addr;
    logic [7:0] dir_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       wrap;
    logic       busy;
`ifdef SOBOL_SCRAMBLE_EN
    logic       scr_we;
    logic [7:0] scr_mask;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sobol_seq_gen #(.INWD(8), .LOGINWD(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .restart   (restart),
        .dir_we    (dir_we),
        .dir_addr  (dir_addr),
        .dir_data  (dir_data),
`ifdef SOBOL_SCRAMBLE_EN
        .scr_we    (scr_we),
        .scr_mask  (scr_mask),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .wrap      (wrap),
        .busy      (busy)
    );

    function automatic logic [7:0] vdc(input int n);
        logic [7:0] g;
        logic [7:0] r;
        g = 8'(n) ^ (8'(n) >> 1);
        for (int i = 0; i < 8; i++) r[7-i] = g[i];
        return r;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d",
                    tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; stop = 0; restart = 0;
        dir_we = 0; dir_addr = 0; dir_data = 0;
        out_ready = 0;
`ifdef SOBOL_SCRAMBLE_EN
        scr_we = 0; scr_mask = 0;
`endif
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // start -> RUN, full period and repeat
        start = 1; tick(); start = 0;
        chk("run_busy", busy, 1);
        chk("run_valid", out_valid, 1);
        chk("run_first", out_data, 0);
        out_ready = 1;
        for (int n = 1; n < 256; n++) begin
            tick();
            chk("seq_data", out_data, vdc(n));
            chk("seq_nowrap", wrap, 0);
        end
        tick();
        chk("wrap_pulse", wrap, 1);
        chk("wrap_data", out_data, 0);
        for (int n = 1; n < 8; n++) begin
            tick();
            chk("rep_data", out_data, vdc(n));
            chk("rep_nowrap", wrap, 0);
        end
        out_ready = 0;

        // start+stop together: stop wins
        start = 1; stop = 1; tick();
        start = 0; stop = 0;
        chk("stop_busy", busy, 0);
        chk("stop_valid", out_valid, 0);
        start = 1; stop = 1; tick();
        start = 0; stop = 0;
        chk("idle_ss", busy, 0);
        restart = 1; tick(); restart = 0;
        chk("idle_restart", out_data, 0);

        // table write in IDLE
        dir_we = 1; dir_addr = 0; dir_data = 8'h01;
        tick(); dir_we = 0;
        start = 1; tick(); start = 0;
        chk("w_first", out_data, 0);
        out_ready = 1; tick(); out_ready = 0;
        chk("w_step", out_data, 8'h01);
        // write in RUN must be ignored
        dir_we = 1; dir_addr = 0; dir_data = 8'h80;
        tick(); dir_we = 0;
        out_ready = 1; tick();
        chk("w_run_a", out_data, 8'h41);
        tick(); out_ready = 0;
        chk("w_run_b", out_data, 8'h40);

        // restore default table
        stop = 1; tick(); stop = 0;
        dir_we = 1; dir_addr = 0; dir_data = 8'h80;
        tick(); dir_we = 0;
        restart = 1; tick(); restart = 0;
        start = 1; tick(); start = 0;

        // stall at 192
        out_ready = 1;
        tick(); chk("st_128", out_data, 128);
        tick(); chk("st_192", out_data, 192);
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data", out_data, 192);
            chk("stall_valid", out_valid, 1);
        end
        out_ready = 1;
        tick(); chk("st_resume", out_data, 64);

        // restart with a step at cnt=3
        restart = 1; tick(); restart = 0;
        chk("rs_data", out_data, 0);
        chk("rs_wrap", wrap, 0);
        tick(); chk("rs_next", out_data, 128);

        // asynchronous reset mid-RUN
        rst_n = 0; #1;
        chk("ar_data", out_data, 0);
        chk("ar_busy", busy, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_wrap", wrap, 0);
        out_ready = 0;
        tick(); rst_n = 1;
        tick();
        start = 1; tick(); start = 0;
        out_ready = 1;
        tick(); chk("ar_s1", out_data, 128);
        tick(); chk("ar_s2", out_data, 192);
        tick(); chk("ar_s3", out_data, 64);
        out_ready = 0;

`ifdef SOBOL_SCRAMBLE_EN
        stop = 1; tick(); stop = 0;
        scr_we = 1; scr_mask = 8'hFF; tick(); scr_we = 0;
        restart = 1; tick(); restart = 0;
        start = 1; tick(); start = 0;
        chk("scr_0", out_data, 255);
        out_ready = 1;
        tick(); chk("scr_1", out_data, 127);
        tick(); chk("scr_2", out_data, 63);
        tick(); chk("scr_3", out_data, 191);
        out_ready = 0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
